i2c_target_rx: RTL and testbench

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_target_rx.sv | 117 +++++++++++
 tb/tb_i2c_target_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target that ACKs its address and queues received bytes in a FIFO
// Ports: core_clk/core_rst clock and sync reset; scl_in/sda_in async bus inputs; sda_out open-drain drive;
//        rx_data/rx_valid/rx_ready FIFO head handshake; busy, addr_match, overflow status flags.
module i2c_target_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h78,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       addr_match,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_e;
  state_e        state_q;
  logic [2:0]    scl_q, sda_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q, last_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          scl_rise, scl_fall, start, stop, byte_done, full, push, pop;
  // [0],[1] synchronizer stages, [2] previous synchronized value
  always_ff @(posedge core_clk)
    if (core_rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  always_comb begin
    scl_rise  = scl_q[1] & ~scl_q[2];
    scl_fall  = ~scl_q[1] & scl_q[2];
    start     = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    stop      = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    byte_done = scl_fall && bit_cnt_q == 4'd8;
    rx_valid  = cnt_q != '0;
    full      = cnt_q == CW'(FIFO_DEPTH);
    // start/stop need SCL high, so they can never coincide with a falling edge
    push      = state_q == DATA && byte_done && !full;
    pop       = rx_valid & rx_ready;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    rx_data   = rx_valid ? mem_q[rptr_q] : last_q;
  end
  always_ff @(posedge core_clk)
    if (core_rst) begin
      state_q    <= IDLE;
      sda_out    <= 1'b1;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      overflow   <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else if (stop) begin
      state_q    <= IDLE;
      sda_out    <= 1'b1;
      busy       <= 1'b0;
      addr_match <= 1'b0;
    end else if (start) begin
      state_q    <= ADDR;
      sda_out    <= 1'b1;
      busy       <= 1'b1;
      addr_match <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_q   <= {shift_q[6:0], sda_q[1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (byte_done && state_q == ADDR) begin
            state_q    <= (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) ? ADDR_ACK : IGNORE;
            addr_match <= shift_q[7:1] == SLAVE_ADDR && !shift_q[0];
            sda_out    <= !(shift_q[7:1] == SLAVE_ADDR && !shift_q[0]);
          end else if (byte_done) begin
            state_q  <= full ? IGNORE : DATA_ACK;
            overflow <= overflow | full;
            sda_out  <= full;
          end
        end
        ADDR_ACK, DATA_ACK:
          if (scl_fall) begin
            state_q   <= DATA;
            sda_out   <= 1'b1;
            bit_cnt_q <= '0;
          end
        IDLE, IGNORE: sda_out <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  always_ff @(posedge core_clk)
    if (core_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= shift_q;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) begin
        last_q <= mem_q[rptr_q];
        rptr_q <= rptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: randomized bus-master stimulus checked against a queue-based model of the target
module tb_i2c_target_rx;
  localparam int DEPTH = 4;
  logic       core_clk = 1'b0, core_rst = 1'b1;
  logic       scl = 1'b1, m_sda = 1'b1, rx_ready = 1'b0;
  logic       sda_in, sda_out, rx_valid, busy, addr_match, overflow;
  logic [7:0] rx_data;
  logic [7:0] model_q [$];
  logic [7:0] last_pop = 8'h00;
  bit         ignoring, m_ovf;
  int         n_vec, n_err, pop_cnt;
  assign sda_in = m_sda & sda_out;
  always #5 core_clk = ~core_clk;
  i2c_target_rx #(.SLAVE_ADDR(7'h78), .FIFO_DEPTH(DEPTH)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .scl_in(scl), .sda_in(sda_in), .sda_out(sda_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .addr_match(addr_match), .overflow(overflow));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge core_clk);
  endtask
  // consumer side: every accepted byte must be the oldest byte the model still holds
  always begin
    @(negedge core_clk);
    #2;
    if (!core_rst && rx_valid && rx_ready) begin
      pop_cnt++;
      if (model_q.size() == 0) chk("pop_extra", {31'd0, rx_valid}, 32'd0);
      else begin
        last_pop = model_q.pop_front();
        chk("pop_data", {24'd0, rx_data}, {24'd0, last_pop});
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; cyc(4); scl = 1'b1; cyc(8); scl = 1'b0; cyc(4);
    end
    m_sda = 1'b1; cyc(4); scl = 1'b1; cyc(4);
    ack = !sda_out;
    cyc(4); scl = 1'b0; cyc(4);
    chk("sda_release", {31'd0, sda_out}, 32'd1);
  endtask
  task automatic do_start();
    m_sda = 1'b1; cyc(4); scl = 1'b1; cyc(8); m_sda = 1'b0; cyc(8); scl = 1'b0; cyc(4);
    ignoring = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("match_clr_start", {31'd0, addr_match}, 32'd0);
  endtask
  task automatic do_stop();
    m_sda = 1'b0; cyc(4); scl = 1'b1; cyc(8); m_sda = 1'b1; cyc(8);
    chk("busy_stop", {31'd0, busy}, 32'd0);
    chk("match_stop", {31'd0, addr_match}, 32'd0);
    chk("sda_stop", {31'd0, sda_out}, 32'd1);
  endtask
  task automatic do_addr(input logic [7:0] a);
    logic ack;
    bit   exp;
    exp = a[7:1] == 7'h78 && !a[0];
    send_byte(a, ack);
    chk("addr_ack", {31'd0, ack}, {31'd0, exp});
    chk("addr_match", {31'd0, addr_match}, {31'd0, exp});
    ignoring = !exp;
  endtask
  task automatic do_data(input logic [7:0] b);
    logic ack;
    bit   exp;
    exp = !ignoring && model_q.size() < DEPTH;
    if (exp) model_q.push_back(b);
    else if (!ignoring) begin
      m_ovf    = 1'b1;
      ignoring = 1'b1;
    end
    send_byte(b, ack);
    chk("data_ack", {31'd0, ack}, {31'd0, exp});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask
  task automatic drain();
    rx_ready = 1'b1;
    for (int k = 0; k < 40 && (rx_valid || model_q.size() != 0); k++) cyc(1);
    chk("drain_model", model_q.size(), 32'd0);
    chk("drain_valid", {31'd0, rx_valid}, 32'd0);
    cyc(3);
    chk("empty_hold", {24'd0, rx_data}, {24'd0, last_pop});
    rx_ready = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b;
    int         p0;
    cyc(3);
    chk("rst_sda", {31'd0, sda_out}, 32'd1);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    core_rst = 1'b0;
    cyc(4);
    // single byte with a ready consumer
    rx_ready = 1'b1; p0 = pop_cnt;
    do_start(); do_addr(8'hF0); do_data(8'h01); do_stop();
    chk("one_pop", pop_cnt - p0, 32'd1);
    drain();
    // wrong address, then read request
    do_start(); do_addr(8'hF2); do_data(8'h55); do_stop();
    chk("wrong_addr_nopush", {31'd0, rx_valid}, 32'd0);
    do_start(); do_addr(8'hF1); do_data(8'h66); do_data(8'h77); do_stop();
    chk("read_nopush", {31'd0, rx_valid}, 32'd0);
    // fill past capacity
    do_start(); do_addr(8'hF0);
    for (int i = 2; i <= 6; i++) do_data(8'(i));
    do_stop();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    drain();
    // repeated start keeps the transfer busy
    do_start(); do_addr(8'hF0); do_data(8'h07);
    chk("busy_before_rs", {31'd0, busy}, 32'd1);
    do_start(); do_addr(8'hF0); do_data(8'h08); do_stop();
    drain();
    // reset in the middle of a data byte
    rx_ready = 1'b1;
    do_start(); do_addr(8'hF0);
    b = 8'hA5;
    for (int i = 7; i >= 5; i--) begin
      m_sda = b[i]; cyc(4); scl = 1'b1; cyc(8); scl = 1'b0; cyc(4);
    end
    m_sda = b[4]; cyc(2);
    core_rst = 1'b1; cyc(1);
    chk("mrst_sda", {31'd0, sda_out}, 32'd1);
    chk("mrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mrst_data", {24'd0, rx_data}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_match", {31'd0, addr_match}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
    core_rst = 1'b0; model_q.delete(); m_ovf = 1'b0; last_pop = 8'h00;
    cyc(4);
    p0 = pop_cnt;
    do_start(); do_addr(8'hF0); do_data(8'h01); do_stop();
    chk("mrst_one_pop", pop_cnt - p0, 32'd1);
    drain();
    // randomized transfers with the consumer stalled during writes
    for (int t = 0; t < 12; t++) begin
      rx_ready = 1'b0;
      do_start();
      for (int s = 0; s < 1 + int'($urandom_range(0, 1)); s++) begin
        int sel;
        if (s > 0) do_start();
        sel = $urandom_range(0, 3);
        do_addr(sel == 3 ? 8'($urandom) : (sel == 2 ? 8'hF1 : 8'hF0));
        for (int n = $urandom_range(0, 5); n > 0; n--) do_data(8'($urandom));
      end
      do_stop();
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
